// File: rtl/gumnut_alu_mc_if.sv
// Request/response bundle between Gumnut decode, the multi-cycle ALU and write-back.
// The master side is decode plus write-back; the slave side is the ALU.
interface gumnut_alu_mc_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic             op_shift;
  logic [2:0]       func;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [CNT_W-1:0] shift_count;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_c;
  logic             flag_z;
  logic             busy;

  modport master (
    output in_valid, op_shift, func, op_a, op_b, shift_count, out_ready,
    input  in_ready, out_valid, result, flag_c, flag_z, busy
  );

  modport slave (
    input  in_valid, op_shift, func, op_a, op_b, shift_count, out_ready,
    output in_ready, out_valid, result, flag_c, flag_z, busy
  );
endinterface

// File: rtl/gumnut_alu_mc.sv
// Multi-cycle Gumnut ALU: arith/logic ops and shifts/rotates with a registered
// carry/zero flag file. Shifts run 1 bit/cycle (BARREL=0) or in one cycle (BARREL=1).
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | waiting for a request
//  S_SHIFT | iterative shift in progress, one bit per cycle
//  S_DONE  | result and flags valid, held until the consumer takes them
module gumnut_alu_mc #(
  parameter int WIDTH  = 8,
  parameter bit BARREL = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  gumnut_alu_mc_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_z_q, flag_z_d;
  logic [WIDTH-1:0] sh_val_q, sh_val_d;
  logic [CNT_W-1:0] sh_cnt_q, sh_cnt_d;
  logic [1:0]       sh_fn_q, sh_fn_d;

  logic             in_ready;
  logic             accept;
  logic             start_iter;
  logic [CNT_W-1:0] eff_cnt;
  logic [WIDTH:0]   arith_r;
  logic [WIDTH:0]   imm_sh;
  logic [WIDTH:0]   imm_r;
  logic [WIDTH:0]   step_r;

  // Arithmetic done at WIDTH+1 bits; the top bit is carry-out or borrow.
  function automatic logic [WIDTH:0] arith_op(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [2:0]       fn,
                                              input logic             cin);
    logic [WIDTH:0] ext_a;
    logic [WIDTH:0] ext_b;
    logic [WIDTH:0] ext_c;
    logic [WIDTH:0] r;
    ext_a = {1'b0, a};
    ext_b = {1'b0, b};
    ext_c = {{WIDTH{1'b0}}, cin};
    r     = '0;
    case (fn)
      3'b000:  r = ext_a + ext_b;
      3'b001:  r = ext_a + ext_b + ext_c;
      3'b010:  r = ext_a - ext_b;
      3'b011:  r = ext_a - ext_b - ext_c;
      3'b100:  r = {1'b0, a & b};
      3'b101:  r = {1'b0, a | b};
      3'b110:  r = {1'b0, a ^ b};
      default: r = {1'b0, a & ~b};
    endcase
    return r;
  endfunction

  // One-bit shift/rotate; top bit of the return value is the bit moved out.
  function automatic logic [WIDTH:0] shift_step(input logic [WIDTH-1:0] v,
                                                input logic [1:0]       fn);
    logic [WIDTH:0] r;
    case (fn)
      2'b00:   r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
      2'b01:   r = {v[0], 1'b0, v[WIDTH-1:1]};
      2'b10:   r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      default: r = {v[0], v[0], v[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  // Barrel shift as a chain of single-bit steps; count 0 leaves C=0.
  function automatic logic [WIDTH:0] shift_multi(input logic [WIDTH-1:0] v,
                                                 input logic [1:0]       fn,
                                                 input logic [CNT_W-1:0] cnt);
    logic [WIDTH:0] r;
    r = {1'b0, v};
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (CNT_W'(i) < cnt) r = shift_step(r[WIDTH-1:0], fn);
    end
    return r;
  endfunction

  assign in_ready = rst_n & ((state_q == S_IDLE) | ((state_q == S_DONE) & bus.out_ready));
  assign accept   = bus.in_valid & in_ready;

  // Iterative builds hand every non-zero shift to the SHIFT state instead.
  assign eff_cnt    = BARREL ? bus.shift_count : '0;
  assign start_iter = bus.op_shift & ~BARREL & (bus.shift_count != '0);
  assign arith_r    = arith_op(bus.op_a, bus.op_b, bus.func, flag_c_q);
  assign imm_sh     = shift_multi(bus.op_a, bus.func[1:0], eff_cnt);
  assign imm_r      = bus.op_shift ? imm_sh : arith_r;
  assign step_r     = shift_step(sh_val_q, sh_fn_q);

  // Next-state logic; flags and result change only on entry to S_DONE.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    sh_val_d = sh_val_q;
    sh_cnt_d = sh_cnt_q;
    sh_fn_d  = sh_fn_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (start_iter) begin
            state_d  = S_SHIFT;
            sh_val_d = bus.op_a;
            sh_cnt_d = bus.shift_count;
            sh_fn_d  = bus.func[1:0];
          end else begin
            state_d  = S_DONE;
            result_d = imm_r[WIDTH-1:0];
            flag_c_d = imm_r[WIDTH];
            flag_z_d = (imm_r[WIDTH-1:0] == '0);
          end
        end else if ((state_q == S_DONE) && bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        sh_val_d = step_r[WIDTH-1:0];
        sh_cnt_d = sh_cnt_q - CNT_W'(1);
        if (sh_cnt_q == CNT_W'(1)) begin
          state_d  = S_DONE;
          result_d = step_r[WIDTH-1:0];
          flag_c_d = step_r[WIDTH];
          flag_z_d = (step_r[WIDTH-1:0] == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any shift in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      sh_val_q <= '0;
      sh_cnt_q <= '0;
      sh_fn_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      sh_val_q <= sh_val_d;
      sh_cnt_q <= sh_cnt_d;
      sh_fn_q  <= sh_fn_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_SHIFT);
  assign bus.result    = result_q;
  assign bus.flag_c    = flag_c_q;
  assign bus.flag_z    = flag_z_q;
endmodule

// File: tb/tb_gumnut_alu_mc.sv
// Directed bench for gumnut_alu_mc: one iterative and one barrel instance,
// selected by sel, checked against hand-computed vectors.
module tb_gumnut_alu_mc;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic       in_valid;
  logic       op_shift;
  logic [2:0] func;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [2:0] shift_count;
  logic       out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gumnut_alu_mc_if #(.WIDTH(8)) if_it ();
  gumnut_alu_mc_if #(.WIDTH(8)) if_bar ();

  assign if_it.in_valid     = in_valid & ~sel;
  assign if_it.op_shift     = op_shift;
  assign if_it.func         = func;
  assign if_it.op_a         = op_a;
  assign if_it.op_b         = op_b;
  assign if_it.shift_count  = shift_count;
  assign if_it.out_ready    = out_ready;
  assign if_bar.in_valid    = in_valid & sel;
  assign if_bar.op_shift    = op_shift;
  assign if_bar.func        = func;
  assign if_bar.op_a        = op_a;
  assign if_bar.op_b        = op_b;
  assign if_bar.shift_count = shift_count;
  assign if_bar.out_ready   = out_ready;

  gumnut_alu_mc #(.WIDTH(8), .BARREL(1'b0)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_it.slave)
  );

  gumnut_alu_mc #(.WIDTH(8), .BARREL(1'b1)) u_bar (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_bar.slave)
  );

  logic       in_ready_o, out_valid_o, flag_c_o, flag_z_o, busy_o;
  logic [7:0] result_o;

  assign in_ready_o  = sel ? if_bar.in_ready  : if_it.in_ready;
  assign out_valid_o = sel ? if_bar.out_valid : if_it.out_valid;
  assign flag_c_o    = sel ? if_bar.flag_c    : if_it.flag_c;
  assign flag_z_o    = sel ? if_bar.flag_z    : if_it.flag_z;
  assign busy_o      = sel ? if_bar.busy      : if_it.busy;
  assign result_o    = sel ? if_bar.result    : if_it.result;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One request end to end; inputs are scrambled right after accept.
  task automatic run_op(input string tag, input logic s, input logic sh, input logic [2:0] fn,
                        input logic [7:0] a, input logic [7:0] b, input logic [2:0] cnt,
                        input logic [7:0] exp_res, input logic exp_c, input logic exp_z,
                        input int exp_lat);
    int   lat;
    int   busy_n;
    int   exp_busy;
    logic got;
    exp_busy = (!s && sh && cnt != 3'd0) ? int'(cnt) : 0;
    @(negedge clk);
    sel = s; in_valid = 1'b1; op_shift = sh; func = fn;
    op_a = a; op_b = b; shift_count = cnt;
    #1;
    chk({tag, " in_ready"}, in_ready_o, 1'b1);
    lat = 0; busy_n = 0; got = 1'b0;
    while (lat < 50 && !got) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        in_valid = 1'b0; op_a = ~op_a; op_b = ~op_b; func = ~func; shift_count = 3'd0;
      end
      #1;
      if (busy_o) busy_n++;
      if (out_valid_o) got = 1'b1;
    end
    chk({tag, " out_valid"}, got, 1'b1);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy_cycles"}, busy_n, exp_busy);
    chk({tag, " result"}, result_o, exp_res);
    chk({tag, " flag_c"}, flag_c_o, exp_c);
    chk({tag, " flag_z"}, flag_z_o, exp_z);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw;
    rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; op_shift = 1'b0; func = 3'd0;
    op_a = 8'd0; op_b = 8'd0; shift_count = 3'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst in_ready", in_ready_o, 1'b0);
    chk("rst it result", if_it.result, 8'h00);
    chk("rst it flags", {if_it.flag_c, if_it.flag_z}, 2'b00);
    chk("rst it valid_busy", {if_it.out_valid, if_it.busy}, 2'b00);
    chk("rst bar result", if_bar.result, 8'h00);
    chk("rst bar flags", {if_bar.flag_c, if_bar.flag_z}, 2'b00);
    chk("rst bar valid_busy", {if_bar.out_valid, if_bar.busy}, 2'b00);
    rst_n = 1'b1;

    //      tag        sel sh  fn      a      b      cnt   res    c     z     lat
    run_op("add",      0, 0, 3'b000, 8'h07, 8'h03, 3'd0, 8'h0A, 1'b0, 1'b0, 1);
    run_op("sub_eq",   0, 0, 3'b010, 8'h03, 8'h03, 3'd0, 8'h00, 1'b0, 1'b1, 1);
    run_op("sub_brw",  0, 0, 3'b010, 8'h03, 8'h05, 3'd0, 8'hFE, 1'b1, 1'b0, 1);
    run_op("add_ovf",  0, 0, 3'b000, 8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b1, 1);
    run_op("addc",     0, 0, 3'b001, 8'h10, 8'h01, 3'd0, 8'h12, 1'b0, 1'b0, 1);
    run_op("sub_brw2", 0, 0, 3'b010, 8'h00, 8'h01, 3'd0, 8'hFF, 1'b1, 1'b0, 1);
    run_op("subc",     0, 0, 3'b011, 8'h10, 8'h01, 3'd0, 8'h0E, 1'b0, 1'b0, 1);
    run_op("and",      0, 0, 3'b100, 8'h03, 8'h03, 3'd0, 8'h03, 1'b0, 1'b0, 1);
    run_op("or",       0, 0, 3'b101, 8'h05, 8'h05, 3'd0, 8'h05, 1'b0, 1'b0, 1);
    run_op("xor",      0, 0, 3'b110, 8'h05, 8'h05, 3'd0, 8'h00, 1'b0, 1'b1, 1);
    run_op("mask",     0, 0, 3'b111, 8'hFF, 8'h0F, 3'd0, 8'hF0, 1'b0, 1'b0, 1);
    run_op("it_rol1",  0, 1, 3'b010, 8'h81, 8'h00, 3'd1, 8'h03, 1'b1, 1'b0, 2);
    run_op("it_shr7",  0, 1, 3'b001, 8'h80, 8'h00, 3'd7, 8'h01, 1'b0, 1'b0, 8);
    run_op("it_ror1",  0, 1, 3'b011, 8'h01, 8'h00, 3'd1, 8'h80, 1'b1, 1'b0, 2);
    run_op("it_shl2",  0, 1, 3'b000, 8'hC0, 8'h00, 3'd2, 8'h00, 1'b1, 1'b1, 3);
    run_op("it_cnt0",  0, 1, 3'b000, 8'h5A, 8'h00, 3'd0, 8'h5A, 1'b0, 1'b0, 1);
    run_op("bar_rol1", 1, 1, 3'b010, 8'h81, 8'h00, 3'd1, 8'h03, 1'b1, 1'b0, 1);
    run_op("bar_shr7", 1, 1, 3'b001, 8'h80, 8'h00, 3'd7, 8'h01, 1'b0, 1'b0, 1);
    run_op("bar_shl2", 1, 1, 3'b000, 8'hC0, 8'h00, 3'd2, 8'h00, 1'b1, 1'b1, 1);
    run_op("bar_f2",   1, 1, 3'b101, 8'h03, 8'h00, 3'd1, 8'h01, 1'b1, 1'b0, 1);
    run_op("bar_ror3", 1, 1, 3'b011, 8'h0C, 8'h00, 3'd3, 8'h81, 1'b1, 1'b0, 1);
    run_op("bar_cnt0", 1, 1, 3'b010, 8'hA5, 8'h00, 3'd0, 8'hA5, 1'b0, 1'b0, 1);

    // Consumer stall for 3 cycles, then a back-to-back accept.
    @(negedge clk);
    sel = 1'b0; out_ready = 1'b0; in_valid = 1'b1; op_shift = 1'b0;
    func = 3'b000; op_a = 8'hF0; op_b = 8'h20; shift_count = 3'd0;
    #1;
    chk("stall in_ready0", in_ready_o, 1'b1);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      func = 3'b010; op_a = 8'h10; op_b = 8'h02;
      #1;
      chk("stall out_valid", out_valid_o, 1'b1);
      chk("stall result", result_o, 8'h10);
      chk("stall flags", {flag_c_o, flag_z_o}, 2'b10);
      chk("stall in_ready", in_ready_o, 1'b0);
      if (i < 2) @(posedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("b2b in_ready", in_ready_o, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("b2b out_valid", out_valid_o, 1'b1);
    chk("b2b result", result_o, 8'h0E);
    chk("b2b flags", {flag_c_o, flag_z_o}, 2'b00);

    // Reset during an iterative shift; flags set beforehand so the clear is visible.
    run_op("pre_rst",  0, 0, 3'b000, 8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b1, 1);
    @(negedge clk);
    sel = 1'b0; in_valid = 1'b1; op_shift = 1'b1; func = 3'b000;
    op_a = 8'h01; op_b = 8'h00; shift_count = 3'd5;
    #1;
    chk("mrst in_ready", in_ready_o, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("mrst busy", busy_o, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("mrst out_valid", out_valid_o, 1'b0);
    chk("mrst flags", {flag_c_o, flag_z_o}, 2'b00);
    chk("mrst busy_clr", busy_o, 1'b0);
    chk("mrst in_ready_low", in_ready_o, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("mrst in_ready_rel", in_ready_o, 1'b1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("mrst in_ready_idle", in_ready_o, 1'b1);
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid_o) saw = 1'b1;
    end
    chk("mrst no_valid", saw, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
